// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer shared by the CPU load/store unit (port c) and a DMA/debug loader (port d).
// Arbitrates, checks legality, drives the byte-enabled memory and formats returned load data.
module dmem_access_ctrl #(
    parameter int ADDR_W       = 17,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [2:0]        c_funct3,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_done,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic              d_err,

    output logic [31:0]       rdata,

    output logic [ADDR_W-3:0] mem_rdaddr,
    output logic [ADDR_W-3:0] mem_wraddr,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR1,
        S_WR2,
        S_ERR
    } state_t;

    // Sizes and extension follow RISC-V funct3; stores have no unsigned forms.
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        case (f3)
            3'b000:  access_legal = 1'b1;
            3'b001:  access_legal = ~off[0];
            3'b010:  access_legal = (off == 2'b00);
            3'b100:  access_legal = ~we;
            3'b101:  access_legal = ~we & ~off[0];
            default: access_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_byteena(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_byteena = 4'b0001 << off;
            2'b01:   store_byteena = 4'b0011 << off;
            default: store_byteena = 4'b1111;
        endcase
    endfunction

    // Replicating the datum into every lane lets the byte enables alone pick the target.
    function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_align = {4{wd[7:0]}};
            2'b01:   store_align = {2{wd[15:0]}};
            default: store_align = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] q, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        sh = q >> {off, 3'b000};
        case (f3)
            3'b000:  load_format = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_format = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_format = {24'd0, sh[7:0]};
            3'b101:  load_format = {16'd0, sh[15:0]};
            default: load_format = q;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               port_q, port_d;

    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [ADDR_W-3:0]  waddr_q;
    logic [3:0]         be_q;
    logic [31:0]        sdata_q;

    logic               grant_d;
    logic               any_req;
    logic               accept;
    logic               sel_we;
    logic [2:0]         sel_f3;
    logic [ADDR_W-1:0]  sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_legal;

    // Port d is forced through once it has lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        any_req   = c_req | d_req;
        grant_d   = d_req & ((starve_q == CNT_W'(STARVE_LIMIT)) | ~c_req);
        accept    = (state_q == S_IDLE) & any_req;
        sel_we    = grant_d ? d_we     : c_we;
        sel_f3    = grant_d ? d_funct3 : c_funct3;
        sel_addr  = grant_d ? d_addr   : c_addr;
        sel_wdata = grant_d ? d_wdata  : c_wdata;
        sel_legal = access_legal(sel_we, sel_f3, sel_addr[1:0]);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        port_d   = port_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    port_d = grant_d;
                    if (grant_d) begin
                        starve_d = '0;
                    end else if (d_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (!sel_legal) begin
                        state_d = S_ERR;
                    end else if (sel_we) begin
                        state_d = S_WR1;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: state_d = S_IDLE;
            S_WR1:     state_d = S_WR2;
            S_WR2:     state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            port_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            port_q   <= port_d;
        end
    end

    // Request payload is captured only at accept; every output is gated by state, so no reset is needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            f3_q    <= sel_f3;
            off_q   <= sel_addr[1:0];
            waddr_q <= sel_addr[ADDR_W-1:2];
            be_q    <= store_byteena(sel_f3, sel_addr[1:0]);
            sdata_q <= store_align(sel_f3, sel_wdata);
        end
    end

    logic done;
    logic wr_phase;
    logic addr_phase;

    // Write enable spans WR1 and WR2 so the memory's read-merge-write sees a stable request twice.
    always_comb begin
        done        = (state_q == S_RD_DATA) | (state_q == S_WR2) | (state_q == S_ERR);
        wr_phase    = (state_q == S_WR1) | (state_q == S_WR2);
        addr_phase  = wr_phase | (state_q == S_RD_ADDR) | (state_q == S_RD_DATA);

        c_done      = done & ~port_q;
        d_done      = done & port_q;
        c_err       = (state_q == S_ERR) & ~port_q;
        d_err       = (state_q == S_ERR) & port_q;

        mem_wren    = wr_phase;
        mem_byteena = wr_phase ? be_q : 4'b0000;
        mem_data    = wr_phase ? sdata_q : 32'd0;
        mem_rdaddr  = addr_phase ? waddr_q : '0;
        mem_wraddr  = addr_phase ? waddr_q : '0;

        rdata       = (state_q == S_RD_DATA) ? load_format(mem_q, f3_q, off_q) : 32'd0;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-enabled memory model, directed vector table,
// randomized accesses against a byte-array reference, arbitration and reset corner cases.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 17;
    localparam int LIMIT  = 8;

    localparam bit C  = 1'b0;
    localparam bit D  = 1'b1;
    localparam bit LD = 1'b0;
    localparam bit ST = 1'b1;
    localparam bit OK = 1'b0;
    localparam bit ER = 1'b1;

    logic              clock;
    logic              reset;
    logic              c_req, c_we, d_req, d_we;
    logic [2:0]        c_funct3, d_funct3;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [31:0]       c_wdata, d_wdata;
    logic              c_done, c_err, d_done, d_err;
    logic [31:0]       rdata;
    logic [ADDR_W-3:0] mem_rdaddr, mem_wraddr;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic [31:0]       mem_q;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err),
        .rdata(rdata),
        .mem_rdaddr(mem_rdaddr), .mem_wraddr(mem_wraddr), .mem_byteena(mem_byteena),
        .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory environment: 2048 words, byte-enabled write, registered read.
    logic [31:0] mem [0:2047];
    logic        mem_clr;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int w = 0; w < 2048; w++) mem[w] <= 32'd0;
        end else if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) mem[mem_wraddr[10:0]][8*b +: 8] <= mem_data[8*b +: 8];
        end
        mem_q <= mem[mem_rdaddr[10:0]];
    end

    // Reference: plain byte array with size/alignment rules.
    logic [7:0] refb [0:8191];

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [16:0] a);
        bit known;
        known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (!we && (f3 == 3'd4 || f3 == 3'd5));
        return known && ((int'(a) % size_of(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [16:0] a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(refb[(int'(a) + i) % 8192]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [16:0] a, input logic [31:0] wd);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n; i++) refb[(int'(a) + i) % 8192] = 8'(wd >> (8 * i));
    endtask

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive_req(input bit port, input bit we, input logic [2:0] f3,
                             input logic [16:0] a, input logic [31:0] wd);
        if (port) begin
            d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd; c_req = 1'b1;
        end
    endtask

    // One uncontended access; observes every cycle at the falling edge.
    task automatic run_access(input bit port, input bit we, input logic [2:0] f3,
                              input logic [16:0] a, input logic [31:0] wd,
                              output bit err, output logic [31:0] rd, output int lat,
                              output int wren_n, output logic [3:0] be_or, output int stray);
        bit seen;
        seen = 1'b0; err = 1'b0; rd = 32'd0; lat = -1; wren_n = 0; be_or = 4'd0; stray = 0;
        @(negedge clock);
        drive_req(port, we, f3, a, wd);
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge clock);
            if (mem_wren) begin
                wren_n++;
                be_or = be_or | mem_byteena;
            end
            if (mem_rdaddr !== mem_wraddr) stray++;
            if (port ? (c_done | c_err) : (d_done | d_err)) stray++;
            if (port ? d_done : c_done) begin
                seen = 1'b1;
                lat  = cyc;
                err  = port ? d_err : c_err;
                rd   = rdata;
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic check_access(input string tag, input bit port, input bit we,
                                input logic [2:0] f3, input logic [16:0] a, input logic [31:0] wd,
                                input bit exp_err, input logic [31:0] exp_rd,
                                input logic [3:0] exp_be);
        bit err;
        logic [31:0] rd;
        logic [3:0] be_or;
        int lat, wren_n, stray;
        run_access(port, we, f3, a, wd, err, rd, lat, wren_n, be_or, stray);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".latency"}, lat, exp_err ? 1 : 2);
        chk({tag, ".wren_cycles"}, wren_n, (we && !exp_err) ? 2 : 0);
        chk({tag, ".byteena"}, 32'(be_or), 32'(exp_be));
        chk({tag, ".stray"}, stray, 0);
        if (we && ref_legal(we, f3, a)) ref_store(f3, a, wd);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [2:0]  f3;
        logic [16:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        logic [3:0]  be;
    } vec_t;

    function automatic vec_t mk(input bit p, input bit we, input logic [2:0] f3,
                                input logic [16:0] a, input logic [31:0] wd, input bit e,
                                input logic [31:0] r, input logic [3:0] be);
        vec_t v;
        v.port = p; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.err = e; v.rd = r; v.be = be;
        return v;
    endfunction

    vec_t tab[$];

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bit          rp, rwe, rerr;
        logic [2:0]  rf3;
        logic [16:0] ra;
        logic [31:0] rwd, rexp;
        logic [3:0]  rbe;
        int          n, cyc, last;
        bit          winner [0:9];
        int          gap [0:9];

        tab.push_back(mk(C, ST, 3'd2, 17'h010, 32'hDEADBEEF, OK, 32'h0,        4'hF));
        tab.push_back(mk(D, LD, 3'd2, 17'h010, 32'h0,        OK, 32'hDEADBEEF, 4'h0));
        tab.push_back(mk(C, ST, 3'd2, 17'h010, 32'h11223344, OK, 32'h0,        4'hF));
        tab.push_back(mk(D, ST, 3'd0, 17'h013, 32'h00000080, OK, 32'h0,        4'h8));
        tab.push_back(mk(C, LD, 3'd0, 17'h013, 32'h0,        OK, 32'hFFFFFF80, 4'h0));
        tab.push_back(mk(D, LD, 3'd4, 17'h013, 32'h0,        OK, 32'h00000080, 4'h0));
        tab.push_back(mk(C, LD, 3'd2, 17'h010, 32'h0,        OK, 32'h80223344, 4'h0));
        tab.push_back(mk(C, ST, 3'd1, 17'h002, 32'h0000A5A5, OK, 32'h0,        4'hC));
        tab.push_back(mk(D, LD, 3'd1, 17'h002, 32'h0,        OK, 32'hFFFFA5A5, 4'h0));
        tab.push_back(mk(C, ST, 3'd2, 17'h004, 32'h12345678, OK, 32'h0,        4'hF));
        tab.push_back(mk(C, LD, 3'd2, 17'h006, 32'h0,        ER, 32'h0,        4'h0));
        tab.push_back(mk(D, ST, 3'd1, 17'h001, 32'h0000FFFF, ER, 32'h0,        4'h0));
        tab.push_back(mk(C, LD, 3'd3, 17'h008, 32'h0,        ER, 32'h0,        4'h0));
        tab.push_back(mk(D, ST, 3'd4, 17'h004, 32'hFFFFFFFF, ER, 32'h0,        4'h0));
        tab.push_back(mk(C, LD, 3'd2, 17'h004, 32'h0,        OK, 32'h12345678, 4'h0));
        tab.push_back(mk(D, LD, 3'd2, 17'h000, 32'h0,        OK, 32'hA5A50000, 4'h0));
        tab.push_back(mk(C, LD, 3'd5, 17'h012, 32'h0,        OK, 32'h00008022, 4'h0));
        tab.push_back(mk(D, LD, 3'd1, 17'h012, 32'h0,        OK, 32'hFFFF8022, 4'h0));
        tab.push_back(mk(C, LD, 3'd0, 17'h011, 32'h0,        OK, 32'h00000033, 4'h0));
        tab.push_back(mk(C, ST, 3'd1, 17'h012, 32'h1234ABCD, OK, 32'h0,        4'hC));
        tab.push_back(mk(D, LD, 3'd2, 17'h010, 32'h0,        OK, 32'hABCD3344, 4'h0));

        c_req = 1'b0; c_we = 1'b0; c_funct3 = 3'd0; c_addr = '0; c_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = '0; d_wdata = 32'd0;
        for (int i = 0; i < 8192; i++) refb[i] = 8'd0;
        reset = 1'b1;
        mem_clr = 1'b1;
        repeat (3) @(negedge clock);
        mem_clr = 1'b0;

        chk("reset.c_done", 32'(c_done), 32'd0);
        chk("reset.d_done", 32'(d_done), 32'd0);
        chk("reset.errs", 32'({c_err, d_err}), 32'd0);
        chk("reset.mem_wren", 32'(mem_wren), 32'd0);
        chk("reset.mem_byteena", 32'(mem_byteena), 32'd0);
        chk("reset.mem_data", mem_data, 32'd0);
        chk("reset.mem_rdaddr", 32'(mem_rdaddr), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        reset = 1'b0;

        foreach (tab[i])
            check_access($sformatf("tab%0d", i), tab[i].port, tab[i].we, tab[i].f3, tab[i].addr,
                         tab[i].wd, tab[i].err, tab[i].rd, tab[i].be);

        for (int i = 0; i < 80; i++) begin
            rp  = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = 17'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) ra = ra & ~17'(size_of(rf3) - 1);
            rwd = $urandom;
            rerr = !ref_legal(rwe, rf3, ra);
            rexp = (!rwe && !rerr) ? ref_load(rf3, ra) : 32'd0;
            rbe  = (rwe && !rerr) ? 4'(((1 << size_of(rf3)) - 1) << (int'(ra) % 4)) : 4'd0;
            check_access($sformatf("rnd%0d", i), rp, rwe, rf3, ra, rwd, rerr, rexp, rbe);
        end

        // Both ports requesting continuously: d must break through after LIMIT losses.
        pulse_reset();
        @(negedge clock);
        drive_req(C, LD, 3'd2, 17'h010, 32'd0);
        drive_req(D, LD, 3'd2, 17'h020, 32'd0);
        n = 0; cyc = 0; last = 0;
        while (n < 10 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (c_done || d_done) begin
                winner[n] = d_done;
                gap[n]    = cyc - last;
                last      = cyc;
                chk($sformatf("starve%0d.rdata", n), rdata,
                    ref_load(3'd2, d_done ? 17'h020 : 17'h010));
                n++;
                if (d_done) d_req = 1'b0;
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
        chk("starve.count", n, 10);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("starve%0d.winner_d", i), 32'(winner[i]), 32'(i == LIMIT));
            chk($sformatf("starve%0d.gap", i), gap[i], (i == 0) ? 2 : 3);
        end

        // Reset while the first write cycle is on the bus.
        @(negedge clock);
        drive_req(C, ST, 3'd2, 17'h030, 32'hCAFEF00D);
        @(negedge clock);
        chk("rstwr.wren_before", 32'(mem_wren), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstwr.wren_async", 32'(mem_wren), 32'd0);
        c_req = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clock);
            if (c_done || d_done || mem_wren) n++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (c_done || d_done || mem_wren) n++;
        end
        chk("rstwr.no_done", n, 0);
        check_access("rstwr.reload", D, LD, 3'd2, 17'h030, 32'd0, OK, ref_load(3'd2, 17'h030), 4'h0);
        check_access("rstwr.store", C, ST, 3'd0, 17'h031, 32'h0000005A, OK, 32'd0, 4'h2);
        check_access("rstwr.load", C, LD, 3'd4, 17'h031, 32'd0, OK, 32'h0000005A, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences all accesses to the 2048x32 byte-enabled data memory and shares it between two requesters: the CPU load/store unit (port c) and a DMA/debug loader (port d). It decodes RISC-V funct3 sizes, drives word address, byte enables and aligned store data, and holds write-enable for two cycles so the memory's read-merge-write completes. It also extracts and sign-extends load data. It sits between the CPU memory stage/DMA engine and the data memory instance.

Parameters:
ADDR_W, 17, byte-address width; word address is addr[ADDR_W-1:2] (15 bits).
STARVE_LIMIT, 8, number of consecutive lost arbitrations by port d before port d is forced to win.

Ports:
clock  in  1  single system clock; also drives the memory read and write clocks.
reset  in  1  asynchronous, active-high.
c_req / d_req  in  1  access request, held until the matching done.
c_we / d_we  in  1  1 = store, 0 = load.
c_funct3 / d_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
c_addr / d_addr  in  ADDR_W  byte address.
c_wdata / d_wdata  in  32  store data, right-aligned.
c_done / d_done  out  1  one-cycle completion pulse.
c_err / d_err  out  1  valid with done; misaligned or illegal funct3.
rdata  out  32  formatted load data, valid only while c_done or d_done is high.
mem_rdaddr, mem_wraddr  out  15  memory word addresses; both carry the same value.
mem_byteena  out  4  byte enables.
mem_data  out  32  lane-aligned store data.
mem_wren  out  1  memory write enable.
mem_q  in  32  memory read data, registered one cycle after the address.

Behaviour:
- Reset (async): state=IDLE, starve_cnt=0, all outputs 0. Reset mid-access abandons the access; mem_wren drops immediately, and no done is issued.
- States: IDLE, RD_ADDR, RD_DATA, WR1, WR2, ERR.
- IDLE arbitration on each edge:
  - If starve_cnt==STARVE_LIMIT and d_req, port d wins.
  - Otherwise c_req wins, then d_req.
  - starve_cnt increments when c wins while d_req=1, and clears when d wins.
- On the winning edge, latch port id, we, funct3, addr[1:0], word address and wdata.
- Legality check at accept:
  - funct3 in {000,001,010,100,101} (stores: 000,001,010 only).
  - Halfword requires addr[0]==0; word requires addr[1:0]==00.
  - Illegal request: go to ERR; next cycle done=1, err=1, rdata=0; no memory write; then IDLE.
- Load: IDLE -> RD_ADDR (mem_rdaddr driven, wren=0) -> RD_DATA (done=1). Done is high 2 cycles after the accept edge.
  - rdata extracts the byte/halfword at the latched offset from mem_q.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store: IDLE -> WR1 -> WR2 (done=1) -> IDLE.
  - mem_wren=1 in both WR1 and WR2, with address, byteena and data stable across both cycles. The first write cycle loads the memory's merge register; the second commits the correct merge.
  - Byte enables: SB 0001<<off; SH 0011<<off; SW 1111.
  - mem_data: SB replicates wdata[7:0] into all lanes; SH replicates wdata[15:0] into both halves; SW passes wdata.
- Every access returns to IDLE for at least one cycle, so there is no accept in the done cycle. Peak throughput is one access per 3 cycles.
- Request fields must be stable while req is high; the controller samples them only at accept.
- Done and err go to the latched port only. The other port's done stays 0.

Test Plan:
- SW addr 0x0010, data 0xDEADBEEF, then LW 0x0010 -> mem_wren high exactly 2 cycles with byteena 1111; load done 2 cycles after accept, rdata=0xDEADBEEF.
- SB 0x0013 data 0x80 over word 0x11223344, then LB 0x0013 and LBU 0x0013 -> byteena 1000; LB rdata=0xFFFFFF80, LBU rdata=0x00000080; word reads 0x80223344.
- SH 0x0002 data 0xA5A5, then LH 0x0002 -> byteena 1100; rdata=0xFFFFA5A5.
- LW 0x0006, SH 0x0001, funct3 011 -> each gives ERR: done+err one cycle after accept, mem_wren never high, memory unchanged.
- c_req and d_req held continuously -> c wins 8 times, d wins on the 9th arbitration, starve_cnt clears, c resumes.
- Assert reset during WR1 -> mem_wren=0 the same cycle, no done; after release state=IDLE and the next request is served normally.
